remote_key_dispatcher: RTL

- Sits between the RemoteController IR decoder (tecla/ready) and downstream consumers of key presses.
- Detects each new decoded key and rejects codes outside the valid key table.
- Queues accepted keys in a small FIFO and presents them one at a time over a valid/ack handshake.
- Flags queue overflow and rejected codes to the system.

---
 rtl/remote_pkg.sv | 28 ++
 rtl/remote_key_fifo.sv | 68 ++++++
 rtl/remote_key_dispatcher.sv | 126 ++++++++++++
 3 files changed

// File: rtl/remote_pkg.sv
// Shared definitions for the remote key dispatcher: key width, the table of
// rejected codes, the key validation function and the output-state encoding.
package remote_pkg;

  localparam int KEY_W     = 8;
  localparam int N_INVALID = 8;

  // Codes inside 0x00..0x1F that the remote never sends as real keys.
  localparam logic [KEY_W-1:0] INVALID_CODES [N_INVALID] = '{
    8'h0A, 8'h0B, 8'h0D, 8'h0E, 8'h15, 8'h19, 8'h1C, 8'h1D
  };

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } out_state_e;

  // A code is accepted when it is in 0x00..0x1F and not in the holes above.
  function automatic logic key_is_valid(input logic [KEY_W-1:0] code);
    logic ok;
    ok = (code <= 8'h1F);
    for (int i = 0; i < N_INVALID; i++) begin
      if (code == INVALID_CODES[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/remote_key_fifo.sv
// Synchronous FIFO with first-word fall-through head data. A push while full
// is only taken when a pop happens at the same edge; a pop while empty is
// ignored. Head data reads as zero while empty.
module remote_key_fifo
  import remote_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [KEY_W-1:0]         wdata_i,
  output logic [KEY_W-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = count_q;

  // Next pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/remote_key_dispatcher.sv
// Remote key dispatcher: turns decoder tecla/ready levels into single key
// events, rejects codes outside the key table, queues accepted keys and
// hands them out over a valid/ack handshake with overflow and error flags.
// Optional build macro REMOTE_DISPATCH_HOLDOFF_EN adds repeat suppression of
// the last accepted key for HOLDOFF_CYCLES clocks.
module remote_key_dispatcher
  import remote_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int HOLDOFF_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_W-1:0]       tecla,
  input  logic                   ready,
  output logic [KEY_W-1:0]       key_out,
  output logic                   key_valid,
  input  logic                   key_ack,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   err_invalid,
  input  logic                   clr_flags
);

  logic       ready_q;
  logic       err_q, err_d;
  logic       ovf_q, ovf_d;
  out_state_e state_q, state_d;

  logic rise, code_ok, suppress, cand, push, pop, drop;
  logic fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] count;

  assign rise    = ready & ~ready_q;
  assign code_ok = key_is_valid(tecla);
  assign pop     = (state_q == PRESENT) & key_ack;
  assign cand    = rise & code_ok & ~suppress;
  // A full queue still accepts a key when the head is popped at the same edge.
  assign push    = cand & (~fifo_full | pop);
  assign drop    = cand & fifo_full & ~pop;

`ifdef REMOTE_DISPATCH_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  logic [HW-1:0]    hold_q, hold_d;
  logic [KEY_W-1:0] last_key_q, last_key_d;

  assign suppress = (hold_q != '0) && (tecla == last_key_q);

  // Holdoff window restarts on each accepted key and counts down to zero.
  always_comb begin
    hold_d     = hold_q;
    last_key_d = last_key_q;
    if (push) begin
      hold_d     = HW'(HOLDOFF_CYCLES);
      last_key_d = tecla;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  // Holdoff counter is cleared by reset; last_key is only meaningful while it runs.
  always_ff @(posedge clk) begin
    if (!rst) hold_q <= '0;
    else      hold_q <= hold_d;
    last_key_q <= last_key_d;
  end
`else
  logic unused_holdoff;
  assign suppress       = 1'b0;
  assign unused_holdoff = (HOLDOFF_CYCLES != 0);
`endif

  // Flag next-state: error is a one-cycle pulse, overflow is sticky with set winning over clear.
  always_comb begin
    err_d = rise & ~code_ok;
    ovf_d = ovf_q;
    if (clr_flags) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  // Output state: PRESENT whenever the queue holds an unconsumed key.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = PRESENT;
      PRESENT: if (pop && !push && (count == ($clog2(DEPTH)+1)'(1))) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Control registers: edge detector, flags and output state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= EMPTY;
    end else begin
      ready_q <= ready;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  remote_key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (tecla),
    .rdata_o (key_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign key_valid   = (state_q == PRESENT) & ~fifo_empty;
  assign fifo_count  = count;
  assign overflow    = ovf_q;
  assign err_invalid = err_q;

endmodule
